wb_src_select_pipe: RTL and testbench
=====================================

// Module: wb_src_select_pipe
// PURPOSE
//   Parametrised, registered writeback-source selector for the 3BC datapath. Picks one of
//   N_IN WIDTH-bit sources (data memory, ALU, immediate, ...) per beat and delivers the result
//   through a 2-entry skid buffer with valid/ready handshake, so writeback can stall without
//   dropping beats. Counts and flags illegal select codes instead of silently emitting zero.
// PARAMETERS
//   WIDTH       8   data width of every source and of out_data
//   N_IN        3   number of sources, >= 2; SEL_W = $clog2(N_IN)
//   ILLEGAL_VAL 0   WIDTH-bit value emitted for sel >= N_IN
// PORTS
//   Clk         in   1             clock, all state rising-edge
//   Reset_n     in   1             asynchronous, active-low reset
//   in_data     in   N_IN*WIDTH    source i at [i*WIDTH +: WIDTH]
//   sel         in   SEL_W         source index, sampled with in_data on accept
//   in_valid    in   1             upstream beat present
//   in_ready    out  1             block can accept a beat this cycle
//   out_data    out  WIDTH         selected value, held stable while out_valid & !out_ready
//   out_valid   out  1             out_data valid
//   out_ready   in   1             downstream takes out_data this cycle
//   flush       in   1             synchronous drop of all buffered beats
//   err_clr     in   1             clears sel_err and err_count
//   sel_err     out  1             sticky: an illegal sel was accepted
//   err_count   out  8             accepted illegal beats, saturating at 255
// BEHAVIOUR
//   - Reset (Reset_n=0, async): state EMPTY; out_valid=0, out_data=0, in_ready=1, skid empty,
//     sel_err=0, err_count=0. Reset mid-transfer discards all buffered beats.
//   - accept = in_valid & in_ready; mux value m = (sel<N_IN) ? in_data[sel] : ILLEGAL_VAL.
//   - in_ready = (state != FULL); derived from registers only, no comb path from out_ready.
//   - Latency: accepted beat appears on out_data the next cycle when buffer not stalled.
//   - States / transitions (per rising edge):
//       EMPTY: accept -> HALF, out<=m.
//       HALF : accept&out_ready -> HALF, out<=m; accept&!out_ready -> FULL, skid<=m;
//              !accept&out_ready -> EMPTY; else hold.
//       FULL : out_ready -> HALF, out<=skid; else hold (no accept possible).
//   - Order preserved: skid content always leaves before any newer beat.
//   - out_data/skid not cleared on dequeue; out_data only meaningful with out_valid.
//   - flush=1: next state EMPTY regardless of accept/out_ready; beat accepted in the flush
//     cycle is dropped but still counted if illegal.
//   - Errors: each accepted beat with sel>=N_IN sets sel_err and increments err_count
//     (saturate 255, no wrap). err_clr same cycle as illegal accept: err_count<=1, sel_err<=1.
//     err_clr alone: both to 0. Illegal beats still flow through with ILLEGAL_VAL.
//   - N_IN a power of 2: no illegal code exists; sel_err/err_count stay 0.
// TESTING
//   1. Reset, N_IN=3: in_data={C=8'h33,B=8'h22,A=8'h11}, sel=0,1,2 back-to-back, out_ready=1
//      -> out_data 11,22,33 on cycles 1,2,3; in_ready stays 1; out_valid 3 cycles.
//   2. Stall: out_ready=0, push 8'hA1 then 8'hA2 -> state FULL, in_ready=0, out_data=A1 held;
//      release out_ready -> A1 then A2 delivered in order, in_ready back to 1 after first pop.
//   3. Illegal: sel=3 accepted -> out_data=ILLEGAL_VAL(0), sel_err=1, err_count=1; 300 illegal
//      beats -> err_count=255; err_clr -> 0/0; err_clr with illegal accept -> count=1, flag=1.
//   4. Flush while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, beat dropped.
//   5. Reset_n pulsed low mid-stall (FULL) asynchronously -> out_valid=0, in_ready=1,
//      sel_err=0, err_count=0 before next clock edge.
//   6. Random valid/ready, WIDTH=16, N_IN=5, 10k beats vs scoreboard -> no loss/dup/reorder,
//      err_count equals count of sel in {5,6,7} (saturated).

Source files
------------

// File: rtl/wb_src_select_pipe.sv
// Selects one of N_IN sources per accepted beat and presents it through a 2-entry skid buffer.
// Latency: an accepted beat appears on out_data one cycle later unless the buffer is stalled.
// Backpressure: in_ready comes from state registers only (low when both entries are held); out_ready never reaches in_ready combinationally.
module wb_src_select_pipe #(
    parameter int               WIDTH       = 8,
    parameter int               N_IN        = 3,
    parameter logic [WIDTH-1:0] ILLEGAL_VAL = '0,
    localparam int              SEL_W       = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    flush,
    input  logic                    err_clr,
    output logic                    sel_err,
    output logic [7:0]              err_count
);

    // EMPTY: nothing held; HALF: out register valid; FULL: out and skid both valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]   r_skid;
    logic               r_sel_err;
    logic [7:0]         r_err_count;

    logic [WIDTH-1:0]   w_mux;
    logic               w_legal;
    logic               w_accept;
    logic               w_illegal;
    logic               w_out_ld;
    logic               w_out_from_skid;
    logic               w_skid_ld;
    logic [7:0]         w_cnt_inc;

    // Handshake status is a pure function of the state register.
    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_out;
    assign sel_err   = r_sel_err;
    assign err_count = r_err_count;

    assign w_accept  = in_valid & in_ready;
    assign w_illegal = w_accept & ~w_legal;
    assign w_cnt_inc = (r_err_count == 8'hFF) ? 8'hFF : (r_err_count + 8'd1);

    // Source mux: only codes below N_IN select a source, anything else yields ILLEGAL_VAL.
    always_comb begin
        w_mux   = ILLEGAL_VAL;
        w_legal = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                w_mux   = in_data[i*WIDTH +: WIDTH];
                w_legal = 1'b1;
            end
        end
    end

    // Next-state and buffer load controls; the skid entry always drains before newer beats.
    always_comb begin
        w_state_nxt     = r_state;
        w_out_ld        = 1'b0;
        w_out_from_skid = 1'b0;
        w_skid_ld       = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_HALF;
                    w_out_ld    = 1'b1;
                end
            end
            ST_HALF: begin
                if (w_accept && out_ready) begin
                    w_out_ld    = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_FULL;
                    w_skid_ld   = 1'b1;
                end else if (out_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    w_state_nxt     = ST_HALF;
                    w_out_ld        = 1'b1;
                    w_out_from_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        // Flush wins over everything: any beat held or accepted this cycle is dropped.
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Data registers; contents are left in place on dequeue and only qualified by out_valid.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_out_ld) begin
                r_out <= w_out_from_skid ? r_skid : w_mux;
            end
            if (w_skid_ld) begin
                r_skid <= w_mux;
            end
        end
    end

    // Illegal-select bookkeeping; a clear coinciding with an illegal beat keeps that beat counted.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sel_err   <= 1'b0;
            r_err_count <= 8'd0;
        end else if (err_clr) begin
            r_sel_err   <= w_illegal;
            r_err_count <= w_illegal ? 8'd1 : 8'd0;
        end else if (w_illegal) begin
            r_sel_err   <= 1'b1;
            r_err_count <= w_cnt_inc;
        end
    end

endmodule

// File: tb/tb_wb_src_select_pipe.sv
// Bench for wb_src_select_pipe: directed vector table on an 8-bit/3-source instance,
// hand sequences for saturation and async reset, random traffic on a 16-bit/5-source instance.
module tb_wb_src_select_pipe;

    logic Clk = 1'b0;
    initial forever #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: WIDTH=8, N_IN=3
    logic        a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic        a_flush, a_err_clr, a_sel_err;
    logic [23:0] a_in_data;
    logic [1:0]  a_sel;
    logic [7:0]  a_out_data, a_err_count;

    // Instance B: WIDTH=16, N_IN=5
    logic        b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic        b_flush, b_err_clr, b_sel_err;
    logic [79:0] b_in_data;
    logic [2:0]  b_sel;
    logic [15:0] b_out_data;
    logic [7:0]  b_err_count;

    wb_src_select_pipe #(.WIDTH(8), .N_IN(3), .ILLEGAL_VAL(8'h00)) dut_a (
        .Clk(Clk), .Reset_n(a_rst_n), .in_data(a_in_data), .sel(a_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .flush(a_flush),
        .err_clr(a_err_clr), .sel_err(a_sel_err), .err_count(a_err_count)
    );

    wb_src_select_pipe #(.WIDTH(16), .N_IN(5), .ILLEGAL_VAL(16'h0000)) dut_b (
        .Clk(Clk), .Reset_n(b_rst_n), .in_data(b_in_data), .sel(b_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .flush(b_flush),
        .err_clr(b_err_clr), .sel_err(b_sel_err), .err_count(b_err_count)
    );

    typedef struct {
        logic        iv;
        logic [1:0]  sel;
        logic [23:0] dat;
        logic        ordy;
        logic        fl;
        logic        clr;
        logic        ov;
        logic        ir;
        logic        chk_d;
        logic [7:0]  od;
        logic        se;
        logic [7:0]  ec;
    } vec_t;

    vec_t vec[$];

    function automatic vec_t mk(int iv, int sel, int dat, int ordy, int fl, int clr,
                                int ov, int ir, int chk_d, int od, int se, int ec);
        vec_t v;
        v.iv = 1'(iv);   v.sel = 2'(sel); v.dat = 24'(dat); v.ordy = 1'(ordy);
        v.fl = 1'(fl);   v.clr = 1'(clr); v.ov = 1'(ov);    v.ir = 1'(ir);
        v.chk_d = 1'(chk_d); v.od = 8'(od); v.se = 1'(se);  v.ec = 8'(ec);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic iv, input logic [1:0] sel, input logic [23:0] dat,
                           input logic ordy, input logic fl, input logic clr);
        a_in_valid = iv; a_sel = sel; a_in_data = dat;
        a_out_ready = ordy; a_flush = fl; a_err_clr = clr;
    endtask

    // Hard stop in case something above never returns.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] q[$];
        logic [95:0] r96;
        logic        m_in_rdy, m_out_vld;
        int          illegal_n, accepted, cycles, sat;

        a_rst_n = 1'b0; b_rst_n = 1'b0;
        drive_a(1'b0, 2'd0, 24'h0, 1'b0, 1'b0, 1'b0);
        b_in_valid = 1'b0; b_sel = 3'd0; b_in_data = '0;
        b_out_ready = 1'b0; b_flush = 1'b0; b_err_clr = 1'b0;

        // ---------------- reset state ----------------
        #3;
        chk("rst out_valid", {31'b0, a_out_valid}, 32'd0);
        chk("rst in_ready",  {31'b0, a_in_ready},  32'd1);
        chk("rst out_data",  {24'b0, a_out_data},  32'd0);
        chk("rst sel_err",   {31'b0, a_sel_err},   32'd0);
        chk("rst err_count", {24'b0, a_err_count}, 32'd0);
        @(negedge Clk); @(negedge Clk);
        a_rst_n = 1'b1; b_rst_n = 1'b1;

        // ---------------- directed table ----------------
        //           iv sel dat        ordy fl clr | ov ir chk od    se ec
        vec.push_back(mk(1, 0, 'h332211, 1, 0, 0,   1, 1, 1, 'h11, 0, 0));
        vec.push_back(mk(1, 1, 'h332211, 1, 0, 0,   1, 1, 1, 'h22, 0, 0));
        vec.push_back(mk(1, 2, 'h332211, 1, 0, 0,   1, 1, 1, 'h33, 0, 0));
        vec.push_back(mk(0, 0, 'h332211, 1, 0, 0,   0, 1, 0, 'h00, 0, 0));
        vec.push_back(mk(1, 0, 'h0000A1, 0, 0, 0,   1, 1, 1, 'hA1, 0, 0));
        vec.push_back(mk(1, 0, 'h0000A2, 0, 0, 0,   1, 0, 1, 'hA1, 0, 0));
        vec.push_back(mk(1, 0, 'h0000A3, 0, 0, 0,   1, 0, 1, 'hA1, 0, 0));
        vec.push_back(mk(0, 0, 'h0000A3, 1, 0, 0,   1, 1, 1, 'hA2, 0, 0));
        vec.push_back(mk(0, 0, 'h000000, 1, 0, 0,   0, 1, 0, 'h00, 0, 0));
        vec.push_back(mk(1, 3, 'h332211, 1, 0, 0,   1, 1, 1, 'h00, 1, 1));
        vec.push_back(mk(0, 0, 'h332211, 1, 0, 1,   0, 1, 0, 'h00, 0, 0));
        vec.push_back(mk(1, 3, 'h332211, 1, 0, 0,   1, 1, 1, 'h00, 1, 1));
        vec.push_back(mk(1, 3, 'h332211, 1, 0, 1,   1, 1, 1, 'h00, 1, 1));
        vec.push_back(mk(1, 3, 'h332211, 1, 0, 0,   1, 1, 1, 'h00, 1, 2));
        vec.push_back(mk(0, 0, 'h332211, 1, 0, 1,   0, 1, 0, 'h00, 0, 0));
        vec.push_back(mk(1, 0, 'h0000B1, 0, 0, 0,   1, 1, 1, 'hB1, 0, 0));
        vec.push_back(mk(1, 1, 'h00B200, 0, 0, 0,   1, 0, 1, 'hB1, 0, 0));
        vec.push_back(mk(1, 0, 'h0000C9, 0, 1, 0,   0, 1, 0, 'h00, 0, 0));
        vec.push_back(mk(1, 0, 'h0000C1, 0, 0, 0,   1, 1, 1, 'hC1, 0, 0));
        vec.push_back(mk(1, 3, 'h332211, 0, 1, 0,   0, 1, 0, 'h00, 1, 1));
        vec.push_back(mk(1, 2, 'hD10000, 1, 0, 0,   1, 1, 1, 'hD1, 1, 1));
        vec.push_back(mk(0, 0, 'h000000, 1, 0, 1,   0, 1, 0, 'h00, 0, 0));

        foreach (vec[i]) begin
            drive_a(vec[i].iv, vec[i].sel, vec[i].dat, vec[i].ordy, vec[i].fl, vec[i].clr);
            @(negedge Clk);
            chk($sformatf("vec%0d out_valid", i), {31'b0, a_out_valid}, {31'b0, vec[i].ov});
            chk($sformatf("vec%0d in_ready", i),  {31'b0, a_in_ready},  {31'b0, vec[i].ir});
            chk($sformatf("vec%0d sel_err", i),   {31'b0, a_sel_err},   {31'b0, vec[i].se});
            chk($sformatf("vec%0d err_count", i), {24'b0, a_err_count}, {24'b0, vec[i].ec});
            if (vec[i].chk_d)
                chk($sformatf("vec%0d out_data", i), {24'b0, a_out_data}, {24'b0, vec[i].od});
        end

        // ---------------- saturation of err_count ----------------
        drive_a(1'b1, 2'd3, 24'h332211, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 300; k++) begin
            @(negedge Clk);
            if (k == 1)   chk("sat out_data illegal", {24'b0, a_out_data}, 32'd0);
            if (k == 254) chk("sat count 254", {24'b0, a_err_count}, 32'd254);
            if (k == 255) chk("sat count 255", {24'b0, a_err_count}, 32'd255);
            if (k == 300) chk("sat count 300 beats", {24'b0, a_err_count}, 32'd255);
        end
        chk("sat sel_err", {31'b0, a_sel_err}, 32'd1);
        drive_a(1'b0, 2'd0, 24'h0, 1'b1, 1'b0, 1'b1);
        @(negedge Clk);
        chk("sat clr count", {24'b0, a_err_count}, 32'd0);
        chk("sat clr flag",  {31'b0, a_sel_err},   32'd0);

        // ---------------- async reset while FULL ----------------
        drive_a(1'b1, 2'd3, 24'h332211, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        drive_a(1'b1, 2'd0, 24'h0000E1, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        chk("arst pre in_ready", {31'b0, a_in_ready}, 32'd0);
        chk("arst pre sel_err",  {31'b0, a_sel_err},  32'd1);
        #2 a_rst_n = 1'b0;
        #1;
        chk("arst out_valid", {31'b0, a_out_valid}, 32'd0);
        chk("arst in_ready",  {31'b0, a_in_ready},  32'd1);
        chk("arst sel_err",   {31'b0, a_sel_err},   32'd0);
        chk("arst err_count", {24'b0, a_err_count}, 32'd0);
        chk("arst out_data",  {24'b0, a_out_data},  32'd0);
        drive_a(1'b0, 2'd0, 24'h0, 1'b1, 1'b0, 1'b0);
        @(negedge Clk);
        a_rst_n = 1'b1;
        drive_a(1'b1, 2'd1, 24'h332211, 1'b1, 1'b0, 1'b0);
        @(negedge Clk);
        chk("arst after out_data", {24'b0, a_out_data}, 32'h22);
        drive_a(1'b0, 2'd0, 24'h0, 1'b1, 1'b0, 1'b0);
        @(negedge Clk);
        chk("arst after drained", {31'b0, a_out_valid}, 32'd0);

        // ---------------- random traffic on instance B ----------------
        illegal_n = 0; accepted = 0; cycles = 0;
        while (accepted < 10000 && cycles < 60000) begin
            cycles++;
            sat = (illegal_n > 255) ? 255 : illegal_n;
            m_in_rdy  = (q.size() < 2);
            m_out_vld = (q.size() > 0);
            chk("rnd out_valid", {31'b0, b_out_valid}, {31'b0, m_out_vld});
            chk("rnd in_ready",  {31'b0, b_in_ready},  {31'b0, m_in_rdy});
            chk("rnd err_count", {24'b0, b_err_count}, 32'(sat));

            r96 = {$urandom, $urandom, $urandom};
            b_in_data   = r96[79:0];
            b_sel       = 3'($urandom_range(0, 7));
            b_in_valid  = ($urandom_range(0, 9) < 7);
            b_out_ready = ($urandom_range(0, 9) < 6);

            if (m_out_vld && b_out_ready) begin
                chk("rnd out_data", {16'b0, b_out_data}, {16'b0, q[0]});
                void'(q.pop_front());
            end
            if (b_in_valid && m_in_rdy) begin
                accepted++;
                if (b_sel < 3'd5) q.push_back(b_in_data[b_sel*16 +: 16]);
                else begin
                    q.push_back(16'h0000);
                    illegal_n++;
                end
            end
            @(negedge Clk);
        end
        chk("rnd beat budget", 32'(accepted), 32'd10000);

        b_in_valid = 1'b0; b_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (q.size() > 0) begin
                chk("drain out_valid", {31'b0, b_out_valid}, 32'd1);
                chk("drain out_data", {16'b0, b_out_data}, {16'b0, q[0]});
                void'(q.pop_front());
            end
            @(negedge Clk);
        end
        sat = (illegal_n > 255) ? 255 : illegal_n;
        chk("rnd final empty",     {31'b0, b_out_valid}, 32'd0);
        chk("rnd final err_count", {24'b0, b_err_count}, 32'(sat));
        chk("rnd final sel_err",   {31'b0, b_sel_err},   {31'b0, (illegal_n > 0)});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
